// File: rtl/pwm_duty_ramp.sv
// ---------------------------------------------------------------------------
// pwm_duty_ramp
//
// Slew-rate limiter placed between the SPI register bank and the PWM
// peripheral. The host writes a target duty cycle. This block drives the duty
// value that the PWM generator actually uses, and moves that value toward the
// target in programmable steps at a programmable rate. A software write
// therefore never produces an abrupt jump in duty. duty_out_o replaces the
// direct pwm_duty_cycle connection into the PWM peripheral.
//
// Parameters
//   WIDTH            duty-cycle width
//   DIV_W            width of the tick-divider count
//
// Ports
//   clk_i            system clock
//   rst_i            asynchronous, active-high reset
//   enable_i         1 = ramp mode, 0 = bypass (duty follows target)
//   target_duty_i    requested duty from the register bank
//   step_i           magnitude of each step (0 behaves as 1)
//   tick_div_i       clocks between steps, minus 1
//   duty_out_o       registered duty value driven to the PWM peripheral
//   busy_o           registered, high while a ramp is in progress
//   at_target_o      combinational, duty_out_o == target_duty_i
//
// Optional feature, enabled by defining PWM_RAMP_FAULT_EN:
//   fault_in_i       sets the fault latch and forces the duty to 0
//   fault_clr_i      clears the latch when fault_in_i is low
//   fault_latched_o  latch state; while set, the duty is held at 0
//
// Known limitation: if tick_div_i is lowered below the running count, the
// count runs up and wraps at 2^DIV_W before it matches again. Software
// should change tick_div_i only while busy_o is low.
// ---------------------------------------------------------------------------
module pwm_duty_ramp #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef PWM_RAMP_FAULT_EN
  input  logic             fault_in_i,
  input  logic             fault_clr_i,
  output logic             fault_latched_o,
`endif
  input  logic             enable_i,
  input  logic [WIDTH-1:0] target_duty_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [DIV_W-1:0] tick_div_i,
  output logic [WIDTH-1:0] duty_out_o,
  output logic             busy_o,
  output logic             at_target_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             busy_q, busy_d;

`ifdef PWM_RAMP_FAULT_EN
  logic             fault_q, fault_d;
`endif

  // Step arithmetic. The differences are taken one bit wider than the duty,
  // so the comparison against the step size cannot wrap. When the remaining
  // distance fits inside one step, the duty lands exactly on the target, so
  // neither direction can overshoot.
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   up_diff;
  logic [WIDTH:0]   down_diff;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] down_val;
  logic             target_above;
  logic             target_equal;
  logic             tick_hit;

  // A step size of zero would stall the ramp forever, so it is promoted to 1.
  always_comb begin
    step_eff     = (step_i == '0) ? WIDTH'(1) : step_i;
    step_ext     = {1'b0, step_eff};
    up_diff      = {1'b0, target_duty_i} - {1'b0, duty_q};
    down_diff    = {1'b0, duty_q} - {1'b0, target_duty_i};
    up_val       = (up_diff <= step_ext) ? target_duty_i : (duty_q + step_eff);
    down_val     = (down_diff <= step_ext) ? target_duty_i : (duty_q - step_eff);
    target_above = (target_duty_i > duty_q);
    target_equal = (target_duty_i == duty_q);
    tick_hit     = (cnt_q == tick_div_i);
  end

  // Next-state logic.
  // The direction is re-evaluated on every edge, so a target that moves
  // across the current duty reverses the ramp without restarting the tick
  // count. Reaching the target, or a target written equal to the current
  // duty, ends the ramp on that same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
`ifdef PWM_RAMP_FAULT_EN
    fault_d = fault_q;
`endif

    if (!enable_i) begin
      // Bypass: the output is the target, registered once.
      duty_d  = target_duty_i;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (target_equal) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (!tick_hit) begin
      cnt_d   = cnt_q + DIV_W'(1);
      state_d = target_above ? RAMP_UP : RAMP_DOWN;
    end else begin
      cnt_d  = '0;
      duty_d = target_above ? up_val : down_val;
      if (duty_d == target_duty_i) begin
        state_d = IDLE;
      end else if (target_duty_i > duty_d) begin
        state_d = RAMP_UP;
      end else begin
        state_d = RAMP_DOWN;
      end
    end

`ifdef PWM_RAMP_FAULT_EN
    // A fault overrides everything else and parks the output at 0. A
    // clear is honoured only while no fault is present. The clearing edge
    // itself leaves the output at 0, and normal ramping from 0 resumes on
    // the following edge.
    if (fault_in_i) begin
      fault_d = 1'b1;
    end else if (fault_clr_i) begin
      fault_d = 1'b0;
    end
    if (fault_in_i || fault_q) begin
      duty_d  = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers. Reset forces all of them
  // immediately, even in the middle of a ramp.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      busy_q  <= busy_d;
    end
  end

`ifdef PWM_RAMP_FAULT_EN
  // Fault latch. Reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_latched_o = fault_q;
`endif

  assign duty_out_o  = duty_q;
  assign busy_o      = busy_q;
  assign at_target_o = (duty_q == target_duty_i);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// ---------------------------------------------------------------------------
// tb_pwm_duty_ramp
//
// Self-checking bench for pwm_duty_ramp in the default build, with the fault
// feature disabled. Expected duty and busy values are written out by hand
// from the intended behaviour. Each expectation is pushed to a scoreboard
// queue when its stimulus is driven, and popped and compared once the
// clock edge has produced the DUT's response.
// ---------------------------------------------------------------------------
module tb_pwm_duty_ramp;

  localparam int WIDTH = 8;
  localparam int DIV_W = 16;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [WIDTH-1:0] targetDuty;
  logic [WIDTH-1:0] stepSize;
  logic [DIV_W-1:0] tickDiv;
  logic [WIDTH-1:0] dutyOut;
  logic             busy;
  logic             atTarget;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] duty;
    logic             busy;
    logic             at;
  } expect_t;

  expect_t sbQ[$];

  typedef struct {
    string            tag;
    logic             en;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] stp;
    logic [DIV_W-1:0] td;
    logic [WIDTH-1:0] expDuty;
    logic             expBusy;
  } vector_t;

  pwm_duty_ramp #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .target_duty_i(targetDuty),
    .step_i       (stepSize),
    .tick_div_i   (tickDiv),
    .duty_out_o   (dutyOut),
    .busy_o       (busy),
    .at_target_o  (atTarget)
  );

  // 10 ns system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends, even if the clock stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive all functional inputs at once
  task automatic applyStimulus(input logic en, input logic [WIDTH-1:0] tgt,
                               input logic [WIDTH-1:0] stp, input logic [DIV_W-1:0] td);
    enable     = en;
    targetDuty = tgt;
    stepSize   = stp;
    tickDiv    = td;
  endtask

  // Compare one popped expectation against the current DUT outputs
  task automatic checkOutput(input expect_t e);
    checkCount++;
    if (dutyOut !== e.duty) begin
      failCount++;
      $display("[TB] FAIL %s duty_out: got %0d expected %0d", e.tag, dutyOut, e.duty);
    end
    checkCount++;
    if (busy !== e.busy) begin
      failCount++;
      $display("[TB] FAIL %s busy: got %0b expected %0b", e.tag, busy, e.busy);
    end
    checkCount++;
    if (atTarget !== e.at) begin
      failCount++;
      $display("[TB] FAIL %s at_target: got %0b expected %0b", e.tag, atTarget, e.at);
    end
  endtask

  // Push the expectation, let one edge happen, then pop and compare
  task automatic runCycle(input string tag, input logic [WIDTH-1:0] expDuty, input logic expBusy);
    expect_t e;
    sbQ.push_back('{tag: tag, duty: expDuty, busy: expBusy, at: (expDuty == targetDuty)});
    @(posedge clk);
    #1;
    e = sbQ.pop_front();
    checkOutput(e);
  endtask

  // Compare without waiting for an edge (asynchronous effects)
  task automatic checkNow(input string tag, input logic [WIDTH-1:0] expDuty, input logic expBusy);
    expect_t e;
    sbQ.push_back('{tag: tag, duty: expDuty, busy: expBusy, at: (expDuty == targetDuty)});
    #1;
    e = sbQ.pop_front();
    checkOutput(e);
  endtask

  vector_t vecs[12];

  initial begin
    // Single-edge vectors: bypass, step of 0, full-scale step, enable
    // re-entry without a jump.
    vecs[0]  = '{"bypassF0",    1'b0, 8'hF0, 8'd0,   16'd0, 8'hF0, 1'b0};
    vecs[1]  = '{"bypass05",    1'b0, 8'h05, 8'd0,   16'd0, 8'h05, 1'b0};
    vecs[2]  = '{"step0a",      1'b1, 8'h08, 8'd0,   16'd0, 8'h06, 1'b1};
    vecs[3]  = '{"step0b",      1'b1, 8'h08, 8'd0,   16'd0, 8'h07, 1'b1};
    vecs[4]  = '{"step0c",      1'b1, 8'h08, 8'd0,   16'd0, 8'h08, 1'b0};
    vecs[5]  = '{"bypass00",    1'b0, 8'h00, 8'd0,   16'd0, 8'h00, 1'b0};
    vecs[6]  = '{"fullStepUp",  1'b1, 8'hFF, 8'hFF,  16'd0, 8'hFF, 1'b0};
    vecs[7]  = '{"fullStepDn",  1'b1, 8'h00, 8'hFF,  16'd0, 8'h00, 1'b0};
    vecs[8]  = '{"divWait",     1'b1, 8'h10, 8'd0,   16'd1, 8'h00, 1'b1};
    vecs[9]  = '{"divStep",     1'b1, 8'h10, 8'd0,   16'd1, 8'h01, 1'b1};
    vecs[10] = '{"bypass10",    1'b0, 8'h10, 8'd0,   16'd1, 8'h10, 1'b0};
    vecs[11] = '{"reEnable",    1'b1, 8'h20, 8'd4,   16'd0, 8'h14, 1'b1};

    rst = 1'b1;
    applyStimulus(1'b1, 8'h80, 8'd10, 16'd0);

    // Reset holds everything at zero even with a target pending
    repeat (2) @(posedge clk);
    #1;
    checkNow("resetHold", 8'd0, 1'b0);

    // First edge after release starts the ramp
    rst = 1'b0;
    runCycle("resetRelease", 8'd10, 1'b1);
    runCycle("rampAfterRst", 8'd20, 1'b1);

    // Reset mid-ramp acts immediately, and ramping resumes from 0
    rst = 1'b1;
    checkNow("resetMidRamp", 8'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    runCycle("resumeFrom0", 8'd10, 1'b1);

    // Park at 0 through bypass
    applyStimulus(1'b0, 8'd0, 8'd10, 16'd0);
    runCycle("park0", 8'd0, 1'b0);

    // Ramp up 0 -> 100, step 10, tick_div 3: steps at k+3, k+7, ... k+39
    applyStimulus(1'b1, 8'd100, 8'd10, 16'd3);
    for (int j = 0; j < 40; j++) begin
      runCycle($sformatf("rampUp%0d", j), 8'(10 * ((j + 1) / 4)), (j != 39));
    end
    runCycle("rampUpHold", 8'd100, 1'b0);

    // Saturating up, then down, without overshoot
    applyStimulus(1'b0, 8'd0, 8'd10, 16'd0);
    runCycle("park0b", 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd25, 8'd10, 16'd0);
    runCycle("satUp1", 8'd10, 1'b1);
    runCycle("satUp2", 8'd20, 1'b1);
    runCycle("satUp3", 8'd25, 1'b0);
    applyStimulus(1'b1, 8'd3, 8'd10, 16'd0);
    runCycle("down1", 8'd15, 1'b1);
    runCycle("down2", 8'd5, 1'b1);
    runCycle("down3", 8'd3, 1'b0);
    runCycle("downHold", 8'd3, 1'b0);

    // Reversal mid-ramp
    applyStimulus(1'b0, 8'd0, 8'd16, 16'd0);
    runCycle("park0c", 8'd0, 1'b0);
    applyStimulus(1'b1, 8'd200, 8'd16, 16'd0);
    runCycle("rev16", 8'd16, 1'b1);
    runCycle("rev32", 8'd32, 1'b1);
    runCycle("rev48", 8'd48, 1'b1);
    runCycle("rev64", 8'd64, 1'b1);
    applyStimulus(1'b1, 8'd40, 8'd16, 16'd0);
    runCycle("revDown48", 8'd48, 1'b1);
    runCycle("revDown40", 8'd40, 1'b0);
    runCycle("revIdle", 8'd40, 1'b0);

    // Bypass latency: unchanged before the edge, target one clock later
    applyStimulus(1'b0, 8'hF0, 8'd0, 16'd0);
    checkNow("bypassBefore", 8'd40, 1'b0);

    // Table-driven single-edge vectors
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].en, vecs[i].tgt, vecs[i].stp, vecs[i].td);
      runCycle(vecs[i].tag, vecs[i].expDuty, vecs[i].expBusy);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
